icache_lines: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines, per-line valid bits, a refill state machine and a whole-cache flush. It sits between the IF stage and the memory controller. Hits return the instruction combinationally in the request cycle. Misses stall IF while the controller fetches the full line word by word over a req/ack handshake.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_lines_if.sv | 24 ++
 rtl/icache_refill.sv | 72 +++++++
 rtl/icache_lines.sv | 103 ++++++++++
 tb/tb_icache_lines.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    localparam int unsigned ICACHE_ADDR_W   = 32;
    localparam int unsigned ICACHE_INDEX_W  = 6;
    localparam int unsigned ICACHE_OFFSET_W = 2;
    localparam int unsigned ICACHE_DATA_W   = 32;
    // Byte-in-word bits below the word offset.
    localparam int unsigned BYTE_OFS_W      = 2;

endpackage

// File: rtl/icache_lines_if.sv
// Word-read handshake between the instruction cache and the memory controller.
interface icache_lines_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_data_i
    );
endinterface

// File: rtl/icache_refill.sv
// Line refill controller: latches the missing line, walks its words over the
// memory handshake and tracks a flush that arrives while the line is in flight.
module icache_refill
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W   = ICACHE_ADDR_W,
    parameter int unsigned OFFSET_W = ICACHE_OFFSET_W,
    parameter int unsigned LINE_W   = ICACHE_ADDR_W - ICACHE_OFFSET_W - BYTE_OFS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                start_i,
    input  logic [LINE_W-1:0]   line_i,
    input  logic                mem_ack_i,
    output logic                busy_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   line_o,
    output logic [OFFSET_W-1:0] cnt_o,
    output logic                fill_o,
    output logic                last_o,
    output logic                flush_pend_o
);

    state_t state;

    assign busy_o = (state == REFILL);
    assign fill_o = mem_req_o & mem_ack_i;
    assign last_o = fill_o & (cnt_o == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            line_o       <= '0;
            cnt_o        <= '0;
            flush_pend_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= REFILL;
                        mem_req_o    <= 1'b1;
                        mem_addr_o   <= {line_i, {(OFFSET_W+BYTE_OFS_W){1'b0}}};
                        line_o       <= line_i;
                        cnt_o        <= '0;
                        flush_pend_o <= 1'b0;
                    end
                end
                REFILL: begin
                    if (flush_i)
                        flush_pend_o <= 1'b1;
                    if (mem_ack_i) begin
                        if (cnt_o == '1) begin
                            state        <= IDLE;
                            mem_req_o    <= 1'b0;
                            cnt_o        <= '0;
                            flush_pend_o <= 1'b0;
                        end else begin
                            cnt_o      <= cnt_o + OFFSET_W'(1);
                            mem_addr_o <= mem_addr_o + ADDR_W'(4);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_lines.sv
// Direct-mapped instruction cache with multi-word lines: tag/valid/data arrays,
// combinational hit path and the write ports fed by the refill controller.
module icache_lines
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W   = ICACHE_ADDR_W,
    parameter int unsigned INDEX_W  = ICACHE_INDEX_W,
    parameter int unsigned OFFSET_W = ICACHE_OFFSET_W,
    parameter int unsigned DATA_W   = ICACHE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              busy_o,
    icache_lines_if.master    mem
);

    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W - BYTE_OFS_W;
    localparam int unsigned LINE_W = TAG_W + INDEX_W;
    localparam int unsigned NLINES = 2 ** INDEX_W;
    localparam int unsigned WPL    = 2 ** OFFSET_W;

    logic [TAG_W-1:0]  tags  [NLINES];
    logic [DATA_W-1:0] words [NLINES*WPL];
    logic [NLINES-1:0] valid;

    logic [ADDR_W-BYTE_OFS_W-1:0] waddr;
    logic [LINE_W-1:0]            line_in;
    logic [INDEX_W-1:0]           idx_in;
    logic [TAG_W-1:0]             tag_in;
    logic [OFFSET_W-1:0]          word_in;
    logic                         hit;
    logic                         miss;

    logic [LINE_W-1:0]   fill_line;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [OFFSET_W-1:0] cnt;
    logic                fill;
    logic                last;
    logic                flush_pend;

    assign waddr   = (ADDR_W-BYTE_OFS_W)'(addr_i >> BYTE_OFS_W);
    assign word_in = waddr[OFFSET_W-1:0];
    assign line_in = waddr[ADDR_W-BYTE_OFS_W-1:OFFSET_W];
    assign idx_in  = line_in[INDEX_W-1:0];
    assign tag_in  = line_in[LINE_W-1:INDEX_W];

    assign fill_idx = fill_line[INDEX_W-1:0];
    assign fill_tag = fill_line[LINE_W-1:INDEX_W];

    assign hit     = req_i & valid[idx_in] & (tags[idx_in] == tag_in) & ~busy_o & ~flush_i;
    assign miss    = req_i & ~hit & ~busy_o;
    assign ready_o = hit;
    assign inst_o  = hit ? words[{idx_in, word_in}] : '0;

    icache_refill #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .LINE_W   (LINE_W)
    ) u_refill (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .start_i      (miss),
        .line_i       (line_in),
        .mem_ack_i    (mem.mem_ack_i),
        .busy_o       (busy_o),
        .mem_req_o    (mem.mem_req_o),
        .mem_addr_o   (mem.mem_addr_o),
        .line_o       (fill_line),
        .cnt_o        (cnt),
        .fill_o       (fill),
        .last_o       (last),
        .flush_pend_o (flush_pend)
    );

    // A flush coinciding with the final ack still leaves the line invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else begin
            if (miss)
                valid[idx_in] <= 1'b0;
            if (last && !flush_pend)
                valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill)
            words[{fill_idx, cnt}] <= mem.mem_data_i;
        if (last)
            tags[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_lines.sv
// Directed plus randomized bench for icache_lines against an array-based cache model.
module tb_icache_lines;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        ready_o;
    logic [31:0] inst_o;
    logic        busy_o;

    icache_lines_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    icache_lines #(
        .ADDR_W   (32),
        .INDEX_W  (6),
        .OFFSET_W (2),
        .DATA_W   (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .ready_o (ready_o),
        .inst_o  (inst_o),
        .busy_o  (busy_o),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference cache contents: 64 lines of 4 words.
    bit          vm [64];
    int unsigned tm [64];
    logic [31:0] dm [64][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) vm[i] = 1'b0;
    endtask

    // One fetch; serves the refill if the model predicts a miss.
    // d = idle cycles before each ack, fl = pulse flush during the second word.
    task automatic access(input logic [31:0] a, input int unsigned d, input bit fl);
        int unsigned idx, w, tg;
        logic [31:0] base;
        idx  = (a >> 4) & 63;
        w    = (a >> 2) & 3;
        tg   = a >> 10;
        base = a & ~32'hF;
        @(posedge clk); #1;
        req_i  = 1'b1;
        addr_i = a;
        @(negedge clk);
        if (vm[idx] && tm[idx] == tg) begin
            chk("hit_ready", 32'(ready_o), 32'd1);
            chk("hit_inst", inst_o, dm[idx][w]);
            chk("hit_noreq", 32'(mem_if.mem_req_o), 32'd0);
            req_i = 1'b0;
        end else begin
            chk("miss_ready", 32'(ready_o), 32'd0);
            chk("miss_inst", inst_o, 32'd0);
            vm[idx] = 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                for (int unsigned j = 0; j <= d; j++) begin
                    @(negedge clk);
                    mem_if.mem_ack_i = 1'b0;
                    if (fl && k == 1 && j == 0) begin
                        flush_i = 1'b1;
                        model_flush();
                    end else begin
                        flush_i = 1'b0;
                    end
                    if (j == 0) chk("refill_req", 32'(mem_if.mem_req_o), 32'd1);
                    chk("refill_addr", mem_if.mem_addr_o, base + 4 * k);
                    if (j == d) begin
                        mem_if.mem_ack_i  = 1'b1;
                        mem_if.mem_data_i = $urandom;
                        dm[idx][k] = mem_if.mem_data_i;
                    end
                end
            end
            @(negedge clk);
            mem_if.mem_ack_i = 1'b0;
            flush_i = 1'b0;
            if (!fl) begin
                vm[idx] = 1'b1;
                tm[idx] = tg;
            end
            chk("fill_busy", 32'(busy_o), 32'd0);
            chk("fill_ready", 32'(ready_o), fl ? 32'd0 : 32'd1);
            chk("fill_inst", inst_o, fl ? 32'd0 : dm[idx][w]);
            req_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        flush_i = 1'b0;
        req_i = 1'b0;
        addr_i = '0;
        mem_if.mem_ack_i = 1'b0;
        mem_if.mem_data_i = '0;
        model_flush();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mreq", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_maddr", mem_if.mem_addr_o, 32'd0);
        rst = 1'b1;

        // First miss, same-line hits, conflicting tag, then re-miss.
        access(32'h10, 0, 0);
        access(32'h14, 0, 0);
        access(32'h1C, 0, 0);
        access(32'h410, 0, 0);
        access(32'h10, 0, 0);
        access(32'h18, 0, 0);

        // Stray ack while idle must not disturb the line.
        @(posedge clk); #1;
        mem_if.mem_ack_i  = 1'b1;
        mem_if.mem_data_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("stray_ack_noreq", 32'(mem_if.mem_req_o), 32'd0);
        @(posedge clk); #1;
        mem_if.mem_ack_i = 1'b0;
        access(32'h10, 0, 0);
        access(32'h1C, 0, 0);

        // Slow memory: three wait cycles per word.
        access(32'h34, 3, 0);
        access(32'h30, 0, 0);

        // Flush while idle, with a request that would otherwise hit.
        @(posedge clk); #1;
        req_i = 1'b1;
        addr_i = 32'h14;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(ready_o), 32'd0);
        chk("flush_inst", inst_o, 32'd0);
        req_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b0;
        model_flush();
        access(32'h10, 0, 0);

        // Flush during a refill leaves the completed line invalid.
        access(32'h50, 1, 1);
        access(32'h50, 0, 0);

        // Reset while the second word is being requested.
        @(posedge clk); #1;
        req_i = 1'b1;
        addr_i = 32'h60;
        @(negedge clk);
        @(negedge clk);
        mem_if.mem_ack_i  = 1'b1;
        mem_if.mem_data_i = 32'hA5A5_0001;
        @(negedge clk);
        mem_if.mem_ack_i = 1'b0;
        req_i = 1'b0;
        chk("rstmid_addr", mem_if.mem_addr_o, 32'h64);
        rst = 1'b0;
        #1;
        chk("rstmid_mreq", 32'(mem_if.mem_req_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        model_flush();
        @(negedge clk);
        rst = 1'b1;
        access(32'h60, 0, 0);

        // Random traffic over a small footprint to mix hits, conflicts and flushes.
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
              | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            access(a, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
